// File: rtl/bp_fifo_mem_responder.sv
// Serial-FIFO memory responder: gathers one 192-bit request, runs it against a local
// word RAM (read/write/AMO) and streams a response back for reads and AMOs.
module bp_fifo_mem_responder #(
    parameter int fifo_width_p = 32,
    parameter int mem_els_p    = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [fifo_width_p-1:0] fifo_i,
    input  logic                    fifo_v_i,
    output logic                    fifo_ready_and_o,
    output logic [fifo_width_p-1:0] fifo_o,
    output logic                    fifo_v_o,
    input  logic                    fifo_ready_and_i,
    output logic                    idle_o,
    output logic [31:0]             served_o
);
    localparam int msg_w_lp = 192;
    localparam int words_lp = msg_w_lp / fifo_width_p;
    localparam int cnt_w_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam int idx_w_lp = $clog2(mem_els_p);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(words_lp - 1);

    localparam logic [1:0] RX   = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] AMO  = 2'd2;
    localparam logic [1:0] TX   = 2'd3;

    localparam logic [7:0] TYPE_RD    = 8'd0;
    localparam logic [7:0] TYPE_WR    = 8'd1;
    localparam logic [7:0] TYPE_UC_RD = 8'd2;
    localparam logic [7:0] TYPE_UC_WR = 8'd3;
    localparam logic [7:0] TYPE_AMO   = 8'd5;
    localparam logic [7:0] SUBOP_SWAP = 8'd3;
    localparam logic [7:0] SUBOP_ADD  = 8'd4;

    logic [1:0]          state_q, state_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic [31:0]         served_q, served_d;
    logic                rst_q;
    logic [msg_w_lp-1:0] msg_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem [mem_els_p];

    logic [7:0]          msg_type, subop, size;
    logic [1:0]          lane;
    logic [31:0]         data;
    logic [idx_w_lp-1:0] idx;
    logic                rx_fire, tx_fire;
    logic                mem_we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [msg_w_lp-1:0] resp;
    logic                unused_bits;

    assign msg_type = msg_q[7:0];
    assign subop    = msg_q[15:8];
    assign lane     = msg_q[17:16];
    assign idx      = msg_q[18 +: idx_w_lp];
    assign size     = msg_q[87:80];
    assign data     = msg_q[183:152];
    assign unused_bits = ^{msg_q[191:184], msg_q[151:144]};

    // Ready is held low for one cycle after reset via rst_q, so it never depends on an input.
    assign fifo_ready_and_o = (state_q == RX) && !rst_q;
    assign fifo_v_o         = (state_q == TX);
    assign idle_o           = (state_q == RX) && (cnt_q == '0);
    assign served_o         = served_q;
    assign rx_fire          = fifo_v_i && fifo_ready_and_o;
    assign tx_fire          = fifo_v_o && fifo_ready_and_i;

    // Response echoes the header and payload; both padding bytes are forced to zero.
    assign resp   = {8'h00, rdata_q, 8'h00, msg_q[143:0]};
    assign fifo_o = resp[cnt_q*fifo_width_p +: fifo_width_p];

    always_comb begin
        mem_we = 1'b0;
        be     = 4'h0;
        wdata  = 32'h0;
        if (state_q == EXEC && (msg_type == TYPE_WR || msg_type == TYPE_UC_WR)) begin
            mem_we = 1'b1;
            case (size)
                8'd0: begin
                    be    = 4'b0001 << lane;
                    wdata = {24'h0, data[7:0]} << (8 * lane);
                end
                8'd1: begin
                    be    = lane[1] ? 4'b1100 : 4'b0011;
                    wdata = lane[1] ? {data[15:0], 16'h0} : {16'h0, data[15:0]};
                end
                default: begin
                    be    = 4'hf;
                    wdata = data;
                end
            endcase
        end else if (state_q == AMO && (subop == SUBOP_SWAP || subop == SUBOP_ADD)) begin
            mem_we = 1'b1;
            be     = 4'hf;
            wdata  = (subop == SUBOP_SWAP) ? data : rdata_q + data;
        end
        if (reset_i) begin
            mem_we = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        served_d = served_q;
        case (state_q)
            RX: begin
                if (rx_fire) begin
                    if (cnt_q == last_cnt_lp) begin
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EXEC: begin
                case (msg_type)
                    TYPE_RD, TYPE_UC_RD: state_d = TX;
                    TYPE_AMO:            state_d = AMO;
                    default: begin
                        state_d  = RX;
                        served_d = served_q + 32'd1;
                    end
                endcase
            end
            AMO: state_d = TX;
            default: begin
                if (tx_fire) begin
                    if (cnt_q == last_cnt_lp) begin
                        cnt_d    = '0;
                        state_d  = RX;
                        served_d = served_q + 32'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        rst_q <= reset_i;
        if (reset_i) begin
            state_q  <= RX;
            cnt_q    <= '0;
            served_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            served_q <= served_d;
            if (rx_fire) begin
                msg_q[cnt_q*fifo_width_p +: fifo_width_p] <= fifo_i;
            end
        end
    end

    // Backing RAM is never reset; EXEC always reads so AMO/TX see the pre-write word.
    always_ff @(posedge clk_i) begin
        if (state_q == EXEC) begin
            rdata_q <= mem[idx];
        end
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: doc/bp_fifo_mem_responder.md
BP_FIFO_MEM_RESPONDER -- requirements
Module: bp_fifo_mem_responder

Interface
REQ-001 fifo_width_p, default 32, width of one serial FIFO word; SHALL divide 192 evenly.
REQ-002 mem_els_p, default 1024, number of 32-bit words in local backing RAM; power of two.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 fifo_i  input  fifo_width_p  serial request word, forward direction.
REQ-006 fifo_v_i  input  1  request word valid.
REQ-007 fifo_ready_and_o  output  1  request word accepted when fifo_v_i & fifo_ready_and_o.
REQ-008 fifo_o  output  fifo_width_p  serial response word, reverse direction.
REQ-009 fifo_v_o  output  1  response word valid.
REQ-010 fifo_ready_and_i  input  1  response word consumed when fifo_v_o & fifo_ready_and_i.
REQ-011 idle_o  output  1  high only in RX state with zero request words collected.
REQ-012 served_o  output  32  count of completed requests (all types), wraps modulo 2^32.

Function
REQ-013 Message is 192 bits, LSB first: msg_type[7:0], subop[15:8], addr[79:16], size[87:80], payload[151:88], data[183:152], padding[191:184]; payload bytes LSB first: speculative, uncached, prefetch, src_did, lce_id, way_id, state, padding.
REQ-014 Word k of a message carries bits [k*fifo_width_p +: fifo_width_p]; N = 192/fifo_width_p words per message, word 0 first.
REQ-015 Msg types: rd=0, wr=1, uc_rd=2, uc_wr=3, amo=5; subops: amoswap=3, amoadd=4.
REQ-016 FSM states RX, EXEC, AMO, TX; reset state RX.
REQ-017 RX: fifo_ready_and_o=1; each accepted word stored at position given by a word counter 0..N-1; on acceptance of word N-1 counter wraps to 0 and next state EXEC.
REQ-018 EXEC (1 cycle, fifo_ready_and_o=0): RAM index = addr[2 +: log2(mem_els_p)], higher addr bits ignored (aliasing).
REQ-019 EXEC, wr/uc_wr: write RAM byte lanes per size (0=1B, 1=2B, else 4B) at lane offset addr[1:0] (2B uses addr[1]), write data taken from low bytes of data field shifted to lane; no response; next state RX; served_o increments.
REQ-020 EXEC, rd/uc_rd: synchronous RAM read; next state TX.
REQ-021 EXEC, amo: synchronous RAM read; next state AMO.
REQ-022 AMO (1 cycle): new = data (amoswap) or old+data mod 2^32 (amoadd), full 32-bit word written; other subops write nothing; response data = old word; next state TX.
REQ-023 Unsupported msg_type (4, 6, 7, ...): no RAM access, no response, next state RX, served_o increments.
REQ-024 Response message: msg_type, subop, addr, size, payload copied from request; data = read/old word; padding fields 0.
REQ-025 TX: fifo_v_o=1, fifo_o = response word at counter; counter advances only on handshake; fifo_o stable while fifo_v_o & ~fifo_ready_and_i; after word N-1 handshake next state RX and served_o increments.
REQ-026 fifo_v_o=0 outside TX; fifo_ready_and_o=0 outside RX; no combinational path input->ready.
REQ-027 Minimum request-to-first-response-word latency after last request word: 2 cycles (rd), 3 cycles (amo).
REQ-028 Throughput: one word per cycle each direction; at most one request outstanding.

Reset
REQ-029 reset_i high: state RX, word counter 0, served_o 0, fifo_v_o 0, fifo_ready_and_o 0 during reset, idle_o 1 after release.
REQ-030 Reset mid-RX or mid-TX discards partial request/response; next message starts at word 0.
REQ-031 RAM contents are not reset.

Verification
REQ-032 wr addr 0x40 size 2 data 0xDEADBEEF, then rd addr 0x40 -> one response, data 0xDEADBEEF, header echoed, no response for write.
REQ-033 wr 4B 0x00000000 at 0x10, wr size 0 data 0xAB addr 0x12, rd 0x10 -> data 0x00AB0000.
REQ-034 amo amoadd addr 0x80 data 5 after wr 0x80=0xFFFFFFFE -> response data 0xFFFFFFFE; subsequent rd -> 0x00000003.
REQ-035 rd with fifo_ready_and_i held 0 for 10 cycles mid-response -> fifo_o stable, no word lost or duplicated, fifo_ready_and_o stays 0.
REQ-036 reset asserted after 3 of 6 request words -> next complete rd message processed correctly, served_o counts from 0.
REQ-037 msg_type 6 request -> no response, served_o +1, idle_o returns high.
